wide_add_sequencer: RTL and testbench

Multi-precision add/subtract sequencer around one `generate_16_bit_adder` instance. Operands arrive as a stream of 16-bit words, least-significant word first. The block feeds each word pair to the adder, chains the inter-word carry from the adder's `g_16`/`p_16` outputs, and streams registered sum words out. It sits between a register-file or DMA source and the result sink, so the team can do 32/64/128-bit arithmetic on the 16-bit CLA datapath.

---
 rtl/wide_add_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_wide_add_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract sequencer streaming 16-bit words LSW first through one CLA.
// Optional subtraction is enabled by defining WIDE_ADD_SUB_EN.

module generate_16_bit_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        g_16,
  output logic        p_16
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp, gs, ps;
  logic [4:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gs = '0;
    ps = '0;
    c  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gs = g[4'(4 * k) +: 4];
      ps = p[4'(4 * k) +: 4];
      gg[2'(k)] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1]) | (ps[3] & ps[2] & ps[1] & gs[0]);
      gp[2'(k)] = &ps;
    end
    // Second lookahead level: group carries straight from c_in
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
    g_16  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    p_16  = &gp;
    gc[4] = g_16 | (p_16 & c_in);
    for (int unsigned k = 0; k < 4; k++) begin
      c[4'(4 * k)] = gc[3'(k)];
      for (int unsigned j = 0; j < 3; j++) begin
        c[4'(4 * k + j + 1)] = g[4'(4 * k + j)] | (p[4'(4 * k + j)] & c[4'(4 * k + j)]);
      end
    end
    sum = p ^ c;
  end
endmodule

module wide_add_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_c,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_carry,
  output logic        out_ovf,
  output logic        busy
);
  localparam int unsigned BW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_sum_q, out_sum_d;
  logic            out_last_q, out_last_d;
  logic            out_carry_q, out_carry_d;
  logic            out_ovf_q, out_ovf_d;
  logic            xfer, first, sub_eff, c_adder, carry_new, g_16, p_16;
  logic [15:0]     b_eff, sum;
`ifdef WIDE_ADD_SUB_EN
  logic            sub_q, sub_d;
`else
  logic            sub_unused;
`endif

  always_comb begin
    in_ready = rst_n & (~out_valid_q | out_ready);
    xfer     = in_valid & in_ready;
    first    = (state_q == IDLE);
`ifdef WIDE_ADD_SUB_EN
    sub_eff  = first ? in_sub : sub_q;
    c_adder  = first ? (in_sub | in_c) : carry_q;
`else
    sub_unused = in_sub;
    sub_eff    = 1'b0;
    c_adder    = first ? in_c : carry_q;
`endif
    b_eff    = sub_eff ? ~in_b : in_b;
  end

  generate_16_bit_adder u_adder (
    .a    (in_a),
    .b    (b_eff),
    .c_in (c_adder),
    .sum  (sum),
    .g_16 (g_16),
    .p_16 (p_16)
  );

  always_comb begin
    carry_new   = g_16 | (p_16 & c_adder);
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
`ifdef WIDE_ADD_SUB_EN
    sub_d       = sub_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum;
      out_last_d  = (beat_cnt_q == LAST_BEAT);
      out_carry_d = carry_new;
      out_ovf_d   = (in_a[15] == b_eff[15]) & (sum[15] != in_a[15]);
      carry_d     = carry_new;
`ifdef WIDE_ADD_SUB_EN
      if (first) sub_d = in_sub;
`endif
      if (beat_cnt_q == LAST_BEAT) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = RUN;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
`ifdef WIDE_ADD_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_sum   = out_sum_q;
    out_last  = out_last_q;
    out_carry = out_carry_q & out_last_q;
    out_ovf   = out_ovf_q & out_last_q;
    busy      = (state_q == RUN);
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: 64-bit (WORDS=4) and single-word instances against a
// whole-operation arithmetic model; honours WIDE_ADD_SUB_EN.

module tb_wide_add_sequencer;
  typedef struct packed {
    logic [15:0] sum;
    logic        last;
    logic        carry;
    logic        ovf;
  } exp_t;

`ifdef WIDE_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_c, in_sub, out_valid, out_ready, out_last, out_carry, out_ovf, busy;
  logic [15:0] in_a, in_b, out_sum;
  logic s_in_valid, s_in_ready, s_in_c, s_in_sub, s_out_valid, s_out_ready, s_out_last, s_out_carry, s_out_ovf, s_busy;
  logic [15:0] s_in_a, s_in_b, s_out_sum;

  int   checks = 0;
  int   failures = 0;
  exp_t q4[$];
  exp_t q1[$];
  int   cnt4 = 0;
  bit   chk_en = 1'b0;
  bit   rand_mode = 1'b0;
  int   ready_hold = 0;

  wide_add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  wide_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_c(s_in_c), .in_sub(s_in_sub), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
    .out_last(s_out_last), .out_carry(s_out_carry), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Whole-operation arithmetic: {ovf, carry, 64-bit result}
  function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b, input logic c, input logic sub);
    logic [63:0] be;
    logic        ci;
    logic [64:0] full;
    be   = (SUB_EN && sub) ? ~b : b;
    ci   = (SUB_EN && sub) ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, be} + {64'd0, ci};
    return {(a[63] == be[63]) && (full[63] != a[63]), full[64], full[63:0]};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub);
    logic [15:0] be;
    logic        ci;
    logic [16:0] full;
    be   = (SUB_EN && sub) ? ~b : b;
    ci   = (SUB_EN && sub) ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, be} + {16'd0, ci};
    return {(a[15] == be[15]) && (full[15] != a[15]), full[16], full[15:0]};
  endfunction

  // Sink readiness: forced low for ready_hold cycles, otherwise random or always-on
  initial begin
    out_ready   = 1'b1;
    s_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_hold > 0) begin
        out_ready = 1'b0;
        ready_hold--;
      end else begin
        out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_in_ready_w1", s_in_ready, 0);
      end else begin
        chk("in_ready", in_ready, (q4.size() == 0) || out_ready);
        chk("out_valid", out_valid, q4.size() != 0);
        chk("busy", busy, cnt4 != 0);
        if (q4.size() != 0) begin
          chk("out_sum", out_sum, q4[0].sum);
          chk("out_last", out_last, q4[0].last);
          chk("out_carry", out_carry, q4[0].carry);
          chk("out_ovf", out_ovf, q4[0].ovf);
          if (out_ready) void'(q4.pop_front());
        end
        chk("in_ready_w1", s_in_ready, (q1.size() == 0) || s_out_ready);
        chk("out_valid_w1", s_out_valid, q1.size() != 0);
        chk("busy_w1", s_busy, 0);
        if (q1.size() != 0) begin
          chk("out_sum_w1", s_out_sum, q1[0].sum);
          chk("out_last_w1", s_out_last, q1[0].last);
          chk("out_carry_w1", s_out_carry, q1[0].carry);
          chk("out_ovf_w1", s_out_ovf, q1[0].ovf);
          if (s_out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    q4.delete();
    q1.delete();
    cnt4 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_carry", out_carry, 0);
    chk("reset_out_ovf", out_ovf, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum_w1", s_out_sum, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub, input exp_t e);
    bit ok;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_sub   = sub;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        q4.push_back(e);
        cnt4 = (cnt4 + 1) % 4;
        done = 1'b1;
      end
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic c, input logic sub,
                         input int stall_after, input int abort_after);
    logic [65:0] m, msh;
    logic [63:0] ash, bsh;
    exp_t        e;
    m = model64(a, b, c, sub);
    for (int w = 0; w < 4; w++) begin
      if (w == abort_after) begin
        do_reset();
        return;
      end
      if (w == stall_after) ready_hold = 3;
      msh     = m >> (16 * w);
      ash     = a >> (16 * w);
      bsh     = b >> (16 * w);
      e.sum   = msh[15:0];
      e.last  = (w == 3);
      e.carry = (w == 3) ? m[64] : 1'b0;
      e.ovf   = (w == 3) ? m[65] : 1'b0;
      // Mode inputs after the first word are scrambled: they must be ignored
      if (w == 0) send_word(ash[15:0], bsh[15:0], c, sub, e);
      else        send_word(ash[15:0], bsh[15:0], ~c, ~sub, e);
    end
  endtask

  initial begin
    logic [17:0] m1;
    logic [15:0] a1, b1;
    logic        c1, sub1, ok1;
    exp_t        e1;

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_c = 1'b0; s_in_sub = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    chk("model_ripple", model64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0), {2'b01, 64'h0});
    chk("model_ovf", model64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0), {2'b10, 64'h8000_0000_0000_0000});
    chk("model_sub", model64(64'h1, 64'h2, 1'b0, 1'b1),
        SUB_EN ? {2'b00, 64'hFFFF_FFFF_FFFF_FFFF} : {2'b00, 64'h3});
    chk("model_w1", {48'd0, model16(16'hFFFF, 16'h0001, 1'b1, 1'b0)}, {48'd0, 2'b01, 16'h0001});

    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, -1, -1);
    send_op(64'h1, 64'h2, 1'b0, 1'b1, -1, -1);
    send_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, -1, -1);
    send_op(64'h0123_FFFF_89AB_FFFF, 64'h0F0F_0001_F0F0_0001, 1'b1, 1'b0, 2, -1);
    send_op(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b1, -1, 2);
    send_op(64'h1, 64'h1, 1'b0, 1'b0, -1, -1);
    send_op(64'h1, 64'h1, 1'b1, 1'b0, -1, -1);

    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 5 == 1) rb = ~ra;
      if (k % 7 == 2) ra = '1;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, (k == 20) ? 3 : -1);
    end
    rand_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    s_in_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin
        a1 = 16'hFFFF; b1 = 16'h0001; c1 = 1'b1; sub1 = 1'b0;
      end else begin
        a1 = 16'($urandom); b1 = 16'($urandom);
        c1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      end
      s_in_a = a1; s_in_b = b1; s_in_c = c1; s_in_sub = sub1;
      @(negedge clk);
      ok1 = s_in_ready;
      @(posedge clk);
      if (ok1) begin
        m1 = model16(a1, b1, c1, sub1);
        e1.sum = m1[15:0]; e1.last = 1'b1; e1.carry = m1[16]; e1.ovf = m1[17];
        q1.push_back(e1);
      end
      #1;
    end
    s_in_valid = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_w4", q4.size(), 0);
    chk("drain_w1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
